// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ valid/ready requesters.
// A grant lasts until the requester's last beat, MAX_BURST beats, or a valid drop.
module fifo_wr_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ = 4,
    parameter int MAX_BURST = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_last,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  fifo_full,
    output logic                  fifo_wr_en,
    output logic [WIDTH-1:0]      fifo_din,
    output logic [IDW-1:0]        grant_id,
    output logic                  busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(MAX_BURST - 1);

    state_t           state;
    logic [IDW-1:0]   rr_ptr;
    logic [7:0]       beat_cnt;

    logic             g_valid;
    logic             g_last;
    logic [WIDTH-1:0] g_data;
    logic             in_burst;
    logic             beat_ok;
    logic             burst_end;
    logic [IDW-1:0]   pick;
    logic [IDW-1:0]   next_ptr;

    // First valid requester at or after ptr, wrapping modulo NREQ.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] v,
                                               input logic [IDW-1:0]  ptr);
        logic [IDW-1:0] sel;
        logic           found;
        int             idx;
        sel   = ptr;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && v[idx]) begin
                sel   = IDW'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id == IDW'(i)) begin
                g_valid = req_valid[i];
                g_last  = req_last[i];
                g_data  = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign in_burst   = (state == BURST);
    assign fifo_wr_en = in_burst && g_valid && !fifo_full;
    assign fifo_din   = g_data;
    assign beat_ok    = fifo_wr_en;
    assign burst_end  = (beat_ok && (g_last || (beat_cnt == LAST_CNT))) || !g_valid;
    assign pick       = rr_pick(req_valid, rr_ptr);
    assign next_ptr   = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = in_burst && !fifo_full && (grant_id == IDW'(i));
        end
    end

    // A full-FIFO stall with valid held neither writes nor terminates.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            grant_id <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        grant_id <= pick;
                        beat_cnt <= '0;
                        state    <= BURST;
                        busy     <= 1'b1;
                    end
                end
                BURST: begin
                    if (burst_end) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        rr_ptr <= next_ptr;
                    end else if (beat_ok) begin
                        beat_cnt <= beat_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NREQ=4, WIDTH=8, MAX_BURST=4).
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        reset_n;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] data;
    logic [3:0]  ready;
    logic        full;
    logic        wr_en;
    logic [7:0]  din;
    logic [1:0]  grant;
    logic        busy;

    int total;
    int bad;

    fifo_wr_arbiter #(.WIDTH(8), .NREQ(4), .MAX_BURST(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (valid),
        .req_last   (last),
        .req_data   (data),
        .req_ready  (ready),
        .fifo_full  (full),
        .fifo_wr_en (wr_en),
        .fifo_din   (din),
        .grant_id   (grant),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_wr"}, 32'(wr_en), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_rdy"}, 32'(ready), 32'd0);
    endtask

    task automatic chk_beat(input string tag, input int g, input logic [7:0] d);
        chk({tag, "_grant"}, 32'(grant), 32'(g));
        chk({tag, "_wr"}, 32'(wr_en), 32'd1);
        chk({tag, "_din"}, 32'(din), 32'(d));
        chk({tag, "_rdy"}, 32'(ready), 32'(4'b0001 << g));
        chk({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset_n = 1'b0;
        valid = '0;
        last = '0;
        data = '0;
        full = 1'b0;

        // Reset and idle
        #3;
        chk_idle("rst");
        chk("rst_grant", 32'(grant), 32'd0);
        cyc();
        reset_n = 1'b1;
        for (int n = 0; n < 10; n++) begin
            cyc();
            #1;
            chk_idle("idle");
            chk("idle_grant", 32'(grant), 32'd0);
        end

        // Round-robin fairness: 0,1,2,3,0 with 4 beats each
        cyc();
        valid = 4'hF;
        for (int i = 0; i < 4; i++) data[i*8 +: 8] = 8'hA0 + 8'(i);
        #1;
        chk_idle("rr_start");
        for (int n = 0; n < 5; n++) begin
            for (int b = 0; b < 4; b++) begin
                cyc();
                #1;
                chk_beat("rr_beat", n % 4, 8'hA0 + 8'(n % 4));
            end
            cyc();
            if (n == 4) valid = '0;
            #1;
            chk_idle("rr_gap");
        end

        // Early last from requester 2 (rr_ptr=1)
        cyc();
        valid = 4'b0100;
        data[16 +: 8] = 8'h11;
        #1;
        chk_idle("el_wait");
        cyc();
        #1;
        chk_beat("el_b0", 2, 8'h11);
        cyc();
        data[16 +: 8] = 8'h22;
        last[2] = 1'b1;
        #1;
        chk_beat("el_b1", 2, 8'h22);
        cyc();
        valid = '0;
        last = '0;
        #1;
        chk_idle("el_end");
        cyc();
        valid = 4'b0010;
        data[8 +: 8] = 8'h33;
        last[1] = 1'b1;
        #1;
        chk_idle("wrap_wait");
        cyc();
        #1;
        chk_beat("wrap_b0", 1, 8'h33);
        cyc();
        valid = '0;
        last = '0;
        #1;
        chk_idle("wrap_end");

        // Full stall in requester 0's burst (rr_ptr=2)
        cyc();
        valid = 4'b0001;
        data[0 +: 8] = 8'h50;
        #1;
        cyc();
        #1;
        chk_beat("st_b0", 0, 8'h50);
        cyc();
        data[0 +: 8] = 8'h51;
        #1;
        chk_beat("st_b1", 0, 8'h51);
        cyc();
        data[0 +: 8] = 8'h52;
        full = 1'b1;
        for (int n = 0; n < 5; n++) begin
            if (n > 0) cyc();
            #1;
            chk("st_wr", 32'(wr_en), 32'd0);
            chk("st_rdy", 32'(ready), 32'd0);
            chk("st_grant", 32'(grant), 32'd0);
            chk("st_busy", 32'(busy), 32'd1);
        end
        cyc();
        full = 1'b0;
        #1;
        chk_beat("st_b2", 0, 8'h52);
        cyc();
        data[0 +: 8] = 8'h53;
        #1;
        chk_beat("st_b3", 0, 8'h53);
        cyc();
        valid = '0;
        #1;
        chk_idle("st_end");

        // Reset mid-burst on requester 2 (rr_ptr=1)
        cyc();
        valid = 4'b0100;
        data[16 +: 8] = 8'h70;
        #1;
        cyc();
        #1;
        chk_beat("mr_b0", 2, 8'h70);
        cyc();
        data[16 +: 8] = 8'h71;
        #1;
        chk_beat("mr_b1", 2, 8'h71);
        #1;
        reset_n = 1'b0;
        #1;
        chk_idle("mr_rst");
        chk("mr_grant", 32'(grant), 32'd0);
        cyc();
        #1;
        chk_idle("mr_hold");
        reset_n = 1'b1;
        valid = 4'b0011;
        last = 4'b0011;
        data[0 +: 8] = 8'h80;
        data[8 +: 8] = 8'h81;
        #1;
        chk_idle("mr_rel");
        cyc();
        #1;
        chk_beat("mr_ptr0", 0, 8'h80);
        cyc();
        valid = 4'b0010;
        #1;
        chk_idle("mr_gap");
        cyc();
        #1;
        chk_beat("mr_ptr1", 1, 8'h81);
        cyc();
        valid = '0;
        last = '0;
        #1;
        chk_idle("mr_end");

        // Release on valid drop (rr_ptr=2), then requester 0 next
        cyc();
        valid = 4'b0101;
        data[16 +: 8] = 8'h62;
        data[0 +: 8] = 8'h60;
        #1;
        cyc();
        #1;
        chk_beat("rl_b0", 2, 8'h62);
        cyc();
        valid[2] = 1'b0;
        #1;
        chk("rl_busy", 32'(busy), 32'd1);
        chk("rl_wr", 32'(wr_en), 32'd0);
        chk("rl_rdy", 32'(ready), 32'h4);
        cyc();
        last[0] = 1'b1;
        #1;
        chk_idle("rl_gap");
        cyc();
        #1;
        chk_beat("rl_next", 0, 8'h60);
        cyc();
        valid = '0;
        last = '0;
        #1;
        chk_idle("rl_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
